// File: rtl/dmem_ctrl.sv
// Byte-addressed big-endian data memory with valid/ready request and response channels.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module dmem_ctrl #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_error_q, rsp_error_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            wr_q, wr_d;
  logic            uns_q, uns_d;
  logic [1:0]      size_q, size_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;

  logic [7:0]      mem [DEPTH_BYTES];

  logic            in_idle;
  logic            op_wr, op_uns;
  logic [1:0]      op_size;
  logic [AW-1:0]   op_addr, acc_addr;
  logic [31:0]     op_wdata, load_data;
  logic            acc_err, access;
  logic [3:0][7:0] rb, wb;
  logic [3:0]      lane_en, mem_we;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^req_addr[ADDR_W-1:AW];

  // With no wait states the access happens on the accept edge, straight from the inputs.
  assign in_idle  = (state_q == StIdle);
  assign op_wr    = in_idle ? req_write             : wr_q;
  assign op_uns   = in_idle ? req_unsigned          : uns_q;
  assign op_size  = in_idle ? req_size              : size_q;
  assign op_addr  = in_idle ? req_addr[AW-1:0]      : addr_q;
  assign op_wdata = in_idle ? req_wdata             : wdata_q;

  always_comb begin
    acc_addr = op_addr;
    acc_err  = (op_size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((op_size == 2'b01 && op_addr[0]) || (op_size == 2'b10 && op_addr[1:0] != 2'b00)) begin
      acc_err = 1'b1;
    end
`else
    if (op_size == 2'b01) begin
      acc_addr[0] = 1'b0;
    end else if (op_size == 2'b10) begin
      acc_addr[1:0] = 2'b00;
    end
`endif
  end

  // rb[0] is the lowest address, i.e. the most significant byte.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rb[i] = mem[acc_addr + AW'(i)];
    end
    case (op_size)
      2'b00:   load_data = {{24{~op_uns & rb[0][7]}}, rb[0]};
      2'b01:   load_data = {{16{~op_uns & rb[0][7]}}, rb[0], rb[1]};
      default: load_data = {rb[0], rb[1], rb[2], rb[3]};
    endcase
  end

  always_comb begin
    lane_en = 4'b0000;
    wb      = '0;
    case (op_size)
      2'b00: begin
        lane_en = 4'b0001;
        wb[0]   = op_wdata[7:0];
      end
      2'b01: begin
        lane_en = 4'b0011;
        wb[0]   = op_wdata[15:8];
        wb[1]   = op_wdata[7:0];
      end
      2'b10: begin
        lane_en = 4'b1111;
        wb[0]   = op_wdata[31:24];
        wb[1]   = op_wdata[23:16];
        wb[2]   = op_wdata[15:8];
        wb[3]   = op_wdata[7:0];
      end
      default: lane_en = 4'b0000;
    endcase
  end

  // Gated by rst_n so nothing lands in memory while reset is held.
  assign mem_we = (access && op_wr && !acc_err && rst_n) ? lane_en : 4'b0000;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i]) begin
        mem[acc_addr + AW'(i)] <= wb[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    wr_d        = wr_q;
    uns_d       = uns_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    access      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          wr_d    = req_write;
          uns_d   = req_unsigned;
          size_d  = req_size;
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d   = WaitInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (access) begin
      rsp_error_d = acc_err;
      rsp_rdata_d = (acc_err || op_wr) ? 32'd0 : load_data;
    end
    req_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
      wr_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      wr_q        <= wr_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a zero-wait and a three-wait instance checked against a byte-array model.
module tb_dmem_ctrl;

  localparam int Depth = 256;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]       rsp_valid, rsp_ready, rsp_error;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

  dmem_ctrl #(.DEPTH_BYTES(Depth), .ADDR_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
  );

  dmem_ctrl #(.DEPTH_BYTES(Depth), .ADDR_W(32), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] mdl [2][Depth];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: plain byte-array arithmetic, big-endian, sizes of 1/2/4 bytes.
  task automatic model(input int sel, input bit wr, input bit [1:0] sz, input bit un,
                       input bit [31:0] addr, input bit [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int a, n;
    logic [31:0] v;
    a  = int'(addr % 32'(Depth));
    n  = 1 << sz;
    rd = 32'd0;
    er = 1'b0;
    if (sz == 2'b11) begin
      er = 1'b1;
      return;
    end
    if (a % n != 0) begin
      if (Trap) begin
        er = 1'b1;
        return;
      end
      a = a - a % n;
    end
    if (wr) begin
      for (int i = 0; i < n; i++) mdl[sel][a + i] = 8'(wd >> (8 * (n - 1 - i)));
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(mdl[sel][a + i]);
      if (!un && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endtask

  task automatic txn(input int sel, input bit wr, input bit [1:0] sz, input bit un,
                     input bit [31:0] addr, input bit [31:0] wd, input int stall,
                     output logic [31:0] got);
    logic [31:0] ed;
    logic        ee;
    int          lat;
    int          w;
    w = (sel == 0) ? 0 : 3;
    model(sel, wr, sz, un, addr, wd, ed, ee);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[sel]), 32'd1);
    req_valid[sel]    = 1'b1;
    req_write[sel]    = wr;
    req_size[sel]     = sz;
    req_unsigned[sel] = un;
    req_addr[sel]     = addr;
    req_wdata[sel]    = wd;
    @(posedge clk);
    #1;
    req_valid[sel]    = 1'b0;
    req_write[sel]    = 1'($urandom);
    req_size[sel]     = 2'($urandom);
    req_unsigned[sel] = 1'($urandom);
    req_addr[sel]     = $urandom;
    req_wdata[sel]    = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid[sel] !== 1'b1 && lat < 40);
    chk("latency", 32'(lat), 32'(w + 1));
    chk("rdata", rsp_rdata[sel], ed);
    chk("error", 32'(rsp_error[sel]), 32'(ee));
    chk("req_ready_busy", 32'(req_ready[sel]), 32'd0);
    got = rsp_rdata[sel];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid[sel]), 32'd1);
      chk("stall_rdata", rsp_rdata[sel], ed);
      chk("stall_error", 32'(rsp_error[sel]), 32'(ee));
      chk("stall_req_ready", 32'(req_ready[sel]), 32'd0);
    end
    rsp_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[sel] = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid[sel]), 32'd0);
    chk("req_ready_back", 32'(req_ready[sel]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] word;
    int          r;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_write    = '0;
    req_unsigned = '0;
    req_size     = '0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_req_ready", 32'(req_ready[s]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid[s]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[s], 32'd0);
      chk("reset_rsp_error", 32'(rsp_error[s]), 32'd0);
    end
    rst_n = 1'b1;

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < Depth / 4; i++) txn(s, 1'b1, 2'b10, 1'b0, 32'(4 * i), $urandom, 0, got);
    end

    // Word round trip and byte lanes.
    word = 32'h1122_3344;
    txn(0, 1'b1, 2'b10, 1'b0, 32'h10, word, 0, got);
    for (int i = 0; i < 4; i++) begin
      txn(0, 1'b0, 2'b00, 1'b1, 32'(16 + i), 32'd0, 0, got);
      chk("rt_byte", got, (word >> (8 * (3 - i))) & 32'hFF);
    end
    txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0, got);
    chk("rt_word", got, 32'h1122_3344);

    // Sign and zero extension.
    txn(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h80, 0, got);
    txn(0, 1'b0, 2'b00, 1'b0, 32'h21, 32'd0, 0, got);
    chk("sext_byte", got, 32'hFFFF_FF80);
    txn(0, 1'b0, 2'b00, 1'b1, 32'h21, 32'd0, 0, got);
    chk("zext_byte", got, 32'h0000_0080);
    txn(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h8001, 0, got);
    txn(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 0, got);
    chk("sext_half", got, 32'hFFFF_8001);

    // Misaligned word.
    txn(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'd0, 0, got);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("misalign_trap_rdata", got, 32'd0);
    txn(0, 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFF_FFFF, 0, got);
    txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0, got);
    chk("misalign_no_write", got, 32'h1122_3344);
`else
    chk("misalign_forced", got, 32'h1122_3344);
`endif

    // Reserved size writes nothing; address wraps.
    txn(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hCAFE_BABE, 0, got);
    txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0, got);
    chk("reserved_no_write", got, 32'h1122_3344);
    txn(0, 1'b1, 2'b10, 1'b0, 32'(Depth + 4), 32'hA5A5_5A5A, 0, got);
    txn(0, 1'b0, 2'b10, 1'b0, 32'h4, 32'd0, 0, got);
    chk("wrap_word", got, 32'hA5A5_5A5A);

    // Wait states with five cycles of back-pressure.
    txn(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0BAD_F00D, 0, got);
    txn(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 5, got);
    chk("wait_word", got, 32'h0BAD_F00D);

    // Reset in the second wait cycle drops the pending store.
    txn(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'd0, 0, got);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_size[1]  = 2'b10;
    req_addr[1]  = 32'h40;
    req_wdata[1] = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready[1]), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata[1], 32'd0);
    chk("midrst_rsp_error", 32'(rsp_error[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1, 1'b0, 2'b10, 1'b1, 32'h40, 32'd0, 0, got);
    chk("midrst_discard", got, 32'd0);

    // Random mix on both instances.
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 7));
      txn(k % 2, 1'($urandom), (r == 7) ? 2'b11 : 2'(r % 3), 1'($urandom),
          $urandom, $urandom, int'($urandom_range(0, 2)), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
